// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-cycle controller for program counter, IR and execute stage
//
// Sequences reset-vector load, fetch, wait-for-memory, execute and PC update,
// choosing between a sequential increment and a branch load of the PC.
// Halts on request (at an instruction boundary) or on instruction-memory timeout.
//
// Optional build macro: PC_SEQ_STEP_EN - adds the step input; each step pulse
// seen in IDLE with run=1 runs exactly one instruction, then returns to IDLE.
//
// Ports:
//   clock          in   system clock, rising edge
//   n_reset        in   asynchronous active-low reset
//   run            in   level; 1 allows the instruction cycle to proceed
//   mem_ready      in   instruction memory has valid data
//   exec_done      in   execute stage finished current instruction
//   branch_taken   in   qualified by exec_done; next PC = branch_target
//   branch_target  in   branch destination [ADDR_WIDTH]
//   halt_req       in   request halt at the next instruction boundary
//   step           in   single-step pulse (PC_SEQ_STEP_EN only)
//   pc_data_in     out  value for PC parallel load [ADDR_WIDTH]
//   pc_load        out  PC load strobe
//   pc_increase    out  PC increment strobe
//   fetch_req      out  instruction memory read request
//   ir_load        out  instruction register capture strobe
//   exec_start     out  execute stage start pulse
//   halted         out  core halted
//   timeout_err    out  sticky memory-timeout flag
//   state          out  current state encoding [3]

module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter int                    WAIT_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  n_reset,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic                  exec_done,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
`ifdef PC_SEQ_STEP_EN
    input  logic                  step,
`endif
    output logic [ADDR_WIDTH-1:0] pc_data_in,
    output logic                  pc_load,
    output logic                  pc_increase,
    output logic                  fetch_req,
    output logic                  ir_load,
    output logic                  exec_start,
    output logic                  halted,
    output logic                  timeout_err,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VECTOR = 3'd1,
        FETCH  = 3'd2,
        WAIT   = 3'd3,
        EXEC   = 3'd4,
        UPDATE = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam int                CNT_W    = $clog2(WAIT_TIMEOUT + 1);
    // wait_cnt is 0 in the first WAIT cycle, so this value marks the last allowed one
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

    state_t           st;
    logic             vec_done;
    logic             halt_pend;
    logic [CNT_W-1:0] wait_cnt;
    logic             go;       // IDLE may start an instruction
    logic             cont;     // UPDATE may chain straight into the next fetch

`ifdef PC_SEQ_STEP_EN
    assign go   = run & step;
    assign cont = 1'b0;
`else
    assign go   = run;
    assign cont = run;
`endif

    assign state = st;

    // Outputs are registered alongside the state: each transition sets the
    // strobes that belong to the state being entered, so they are valid for
    // exactly the cycles spent in that state. The UPDATE-cycle pc_load /
    // pc_data_in registers double as the branch decision/target latch.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            st          <= IDLE;
            vec_done    <= 1'b0;
            halt_pend   <= 1'b0;
            wait_cnt    <= '0;
            pc_data_in  <= '0;
            pc_load     <= 1'b0;
            pc_increase <= 1'b0;
            fetch_req   <= 1'b0;
            ir_load     <= 1'b0;
            exec_start  <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            pc_load     <= 1'b0;
            pc_increase <= 1'b0;
            fetch_req   <= 1'b0;
            ir_load     <= 1'b0;
            exec_start  <= 1'b0;
            if (halt_req) begin
                halt_pend <= 1'b1;
            end

            case (st)
                IDLE: begin
                    if (halt_req || halt_pend) begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end else if (go && !vec_done) begin
                        st         <= VECTOR;
                        pc_load    <= 1'b1;
                        pc_data_in <= RESET_VECTOR;
                        vec_done   <= 1'b1;
                    end else if (go) begin
                        st        <= FETCH;
                        fetch_req <= 1'b1;
                    end
                end
                VECTOR: begin
                    st        <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    st        <= WAIT;
                    fetch_req <= 1'b1;
                    wait_cnt  <= '0;
                end
                WAIT: begin
                    // mem_ready is checked first so it wins over a same-cycle timeout
                    if (mem_ready) begin
                        st         <= EXEC;
                        ir_load    <= 1'b1;
                        exec_start <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        st          <= HALT;
                        halted      <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        fetch_req <= 1'b1;
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        st <= UPDATE;
                        if (branch_taken) begin
                            pc_load    <= 1'b1;
                            pc_data_in <= branch_target;
                        end else begin
                            pc_increase <= 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (halt_pend || halt_req) begin
                        st     <= HALT;
                        halted <= 1'b1;
                    end else if (cont) begin
                        st        <= FETCH;
                        fetch_req <= 1'b1;
                    end else begin
                        st <= IDLE;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    st     <= HALT;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        n_reset;
    logic        run;
    logic        mem_ready;
    logic        exec_done;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_req;
    logic        step;
    logic [15:0] pc_data_in;
    logic        pc_load;
    logic        pc_increase;
    logic        fetch_req;
    logic        ir_load;
    logic        exec_start;
    logic        halted;
    logic        timeout_err;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock        (clock),
        .n_reset      (n_reset),
        .run          (run),
        .mem_ready    (mem_ready),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
`ifdef PC_SEQ_STEP_EN
        .step         (step),
`endif
        .pc_data_in   (pc_data_in),
        .pc_load      (pc_load),
        .pc_increase  (pc_increase),
        .fetch_req    (fetch_req),
        .ir_load      (ir_load),
        .exec_start   (exec_start),
        .halted       (halted),
        .timeout_err  (timeout_err),
        .state        (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled at the falling edge
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, " outs"}, {pc_data_in, pc_load, pc_increase, fetch_req, ir_load,
                               exec_start, halted, timeout_err, state}, 32'h0);
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick(2);
        n_reset = 1'b1;
    endtask

    initial begin
        int n_inc, n_ir, n_es, n_wait, n_fetch;
        n_reset = 1'b0; run = 1'b0; mem_ready = 1'b1; exec_done = 1'b1;
        branch_taken = 1'b0; branch_target = 16'h0; halt_req = 1'b0; step = 1'b0;
        tick(2);
        all_zero("reset");

        // ---- sequential run: VECTOR, then 4-cycle instructions
        n_reset = 1'b1; run = 1'b1;
        tick();
        check("vec_state", state, 1);
        check("vec_load", pc_load, 1);
        check("vec_addr", pc_data_in, 16'h0000);
        tick();
        check("fetch_state", state, 2);
        check("fetch_req_f", fetch_req, 1);
        tick();
        check("wait_state", state, 3);
        check("fetch_req_w", fetch_req, 1);
        tick();
        check("exec_state", state, 4);
        check("exec_strobes", {ir_load, exec_start, fetch_req}, 3'b110);
        tick();
        check("upd_state", state, 5);
        check("upd_strobes", {pc_increase, pc_load}, 2'b10);
        n_inc = 0; n_ir = 0; n_es = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_inc += int'(pc_increase); n_ir += int'(ir_load); n_es += int'(exec_start);
        end
        check("inc_per_4", n_inc, 3);
        check("ir_per_4", n_ir, 3);
        check("es_per_4", n_es, 3);
        check("seq_at_update", state, 5);

        // ---- branch
        branch_taken = 1'b1; branch_target = 16'h00A5;
        tick(4);
        check("br_state", state, 5);
        check("br_strobes", {pc_load, pc_increase}, 2'b10);
        check("br_target", pc_data_in, 16'h00A5);
        branch_taken = 1'b0; branch_target = 16'h1234;

        // ---- halt_req in EXEC: instruction completes, then HALT
        tick(3);
        check("hq_exec", state, 4);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("hq_update_inc", {pc_increase, pc_load}, 2'b10);
        check("hq_hold_addr", pc_data_in, 16'h00A5);
        tick();
        check("hq_halted", {halted, state}, {1'b1, 3'd6});
        n_fetch = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_fetch += int'(fetch_req | pc_increase | pc_load);
        end
        check("hq_no_fetch", n_fetch, 0);
        check("hq_absorb", state, 6);

        // ---- reset during WAIT, then VECTOR again
        do_reset();
        mem_ready = 1'b0;
        tick(3);
        check("rw_wait", state, 3);
        @(posedge clock);
        #2 n_reset = 1'b0;
        #1 all_zero("async_reset");
        @(negedge clock);
        n_reset = 1'b1; mem_ready = 1'b1;
        tick();
        check("rw_vector", {state, pc_load}, {3'd1, 1'b1});
        check("rw_vec_addr", pc_data_in, 16'h0000);

        // ---- mem_ready in last allowed WAIT cycle beats timeout
        do_reset();
        mem_ready = 1'b0;
        tick(2);
        tick(15);
        check("tie_last_wait", state, 3);
        mem_ready = 1'b1;
        tick();
        check("tie_exec", {state, ir_load, timeout_err}, {3'd4, 1'b1, 1'b0});

        // ---- memory timeout
        do_reset();
        mem_ready = 1'b0;
        tick(2);
        n_wait = 0;
        for (int i = 0; i < 40 && !halted; i++) begin
            tick();
            if (state == 3'd3) n_wait++;
        end
        check("to_wait_cycles", n_wait, 15);
        check("to_flags", {timeout_err, halted, state}, {1'b1, 1'b1, 3'd6});
        mem_ready = 1'b1;
        tick(5);
        check("to_sticky", {timeout_err, state}, {1'b1, 3'd6});
        n_reset = 1'b0;
        tick();
        check("to_cleared", {timeout_err, halted}, 2'b00);
        n_reset = 1'b1;

`ifdef PC_SEQ_STEP_EN
        // ---- single step: one instruction per pulse
        do_reset();
        run = 1'b1;
        tick(5);
        check("step_idle_wait", state, 0);
        n_inc = 0;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            n_inc += int'(pc_increase);
            for (int i = 0; i < 19; i++) begin
                tick();
                n_inc += int'(pc_increase);
            end
            check("step_idle_between", state, 0);
        end
        check("step_incs", n_inc, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
